// File: rtl/game_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_mode_ctrl
//  Purpose  : Game-mode sequencer. Handles manual play with lives and an
//             invulnerability window, Q-learning auto-play with frame-timed
//             auto-restart, pause/resume, death, and single-cycle Q-update
//             events for the Bot.
//  Options  : GAME_STATS_EN adds survive_frames / best_frames statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module game_mode_ctrl #(
   parameter int POS_W          = 10,
   parameter int TRIGGER_POS    = 624,
   parameter int LIVES          = 3,
   parameter int LIFE_W         = 2,
   parameter int INVULN_FRAMES  = 60,
   parameter int RESTART_FRAMES = 30,
   parameter int EPISODE_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_tick,
   input  logic                 jump_req,
   input  logic                 auto_req,
   input  logic                 pause_req,
   input  logic                 collide,
   input  logic                 jumping,
   input  logic [POS_W-1:0]     obstacle_pos,
   output logic [2:0]           state,
   output logic                 game_run,
   output logic [1:0]           q_event,
   output logic                 q_event_valid,
   output logic [LIFE_W-1:0]    lives_left,
   output logic                 invuln,
   output logic [EPISODE_W-1:0] episode_cnt
`ifdef GAME_STATS_EN
   ,
   output logic [15:0]          survive_frames,
   output logic [15:0]          best_frames
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PLAY  = 3'd1,
      S_AUTO  = 3'd2,
      S_DEAD  = 3'd3,
      S_PAUSE = 3'd4
   } state_t;

   // One counter serves both the invulnerability window and the restart delay;
   // the two never run at the same time.
   localparam int CNT_MAX = (INVULN_FRAMES > RESTART_FRAMES) ? INVULN_FRAMES : RESTART_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]     C_CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]     C_INV_LAST = CNT_W'(INVULN_FRAMES - 1);
   localparam logic [CNT_W-1:0]     C_RST_LAST = CNT_W'(RESTART_FRAMES - 1);
   localparam logic [LIFE_W-1:0]    C_LIVES    = LIFE_W'(LIVES);
   localparam logic [LIFE_W-1:0]    C_LIFE_ONE = LIFE_W'(1);
   localparam logic [POS_W-1:0]     C_TRIG     = POS_W'(TRIGGER_POS);
   localparam logic [EPISODE_W-1:0] C_EP_ONE   = EPISODE_W'(1);

   state_t                state_q, state_d;
   state_t                ret_q, ret_d;
   logic                  auto_restart_q, auto_restart_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [LIFE_W-1:0]     lives_q, lives_d;
   logic                  invuln_q, invuln_d;
   logic [EPISODE_W-1:0]  episode_q, episode_d;
   logic [1:0]            q_event_q, q_event_d;
   logic                  q_valid_q, q_valid_d;
   logic                  game_run_q, game_run_d;
   logic [POS_W-1:0]      prev_pos_q;
   logic                  pass_hit;

   // Obstacle has just arrived at the trigger position
   assign pass_hit = (obstacle_pos == C_TRIG) && (prev_pos_q != obstacle_pos);

   // Next-state, counter, lives and Q-event computation
   always_comb begin
      state_d        = state_q;
      ret_d          = ret_q;
      auto_restart_d = auto_restart_q;
      cnt_d          = cnt_q;
      lives_d        = lives_q;
      invuln_d       = invuln_q;
      episode_d      = episode_q;
      q_event_d      = q_event_q;
      q_valid_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (auto_restart_q) begin
               if (auto_req) begin
                  state_d        = S_DEAD;
                  auto_restart_d = 1'b0;
                  cnt_d          = '0;
               end else if (frame_tick) begin
                  if (cnt_q == C_RST_LAST) begin
                     state_d        = S_AUTO;
                     auto_restart_d = 1'b0;
                     cnt_d          = '0;
                  end else begin
                     cnt_d = cnt_q + C_CNT_ONE;
                  end
               end
            end else if (jump_req) begin
               state_d = S_PLAY;
               lives_d = C_LIVES;
            end else if (auto_req) begin
               state_d = S_AUTO;
            end
         end

         S_PLAY: begin
            if (collide && !invuln_q) begin
               if (lives_q > C_LIFE_ONE) begin
                  lives_d  = lives_q - C_LIFE_ONE;
                  invuln_d = 1'b1;
                  cnt_d    = '0;
               end else begin
                  lives_d = '0;
                  state_d = S_DEAD;
               end
            end else begin
               // A collision swallowed by invulnerability does not block pause
               if (invuln_q && frame_tick) begin
                  if (cnt_q == C_INV_LAST) begin
                     invuln_d = 1'b0;
                     cnt_d    = '0;
                  end else begin
                     cnt_d = cnt_q + C_CNT_ONE;
                  end
               end
               if (pause_req) begin
                  ret_d   = S_PLAY;
                  state_d = S_PAUSE;
               end
            end
         end

         S_AUTO: begin
            if (collide) begin
               state_d        = S_IDLE;
               auto_restart_d = 1'b1;
               cnt_d          = '0;
               episode_d      = episode_q + C_EP_ONE;
               q_event_d      = jumping ? 2'b11 : 2'b10;
               q_valid_d      = 1'b1;
            end else begin
               if (pass_hit) begin
                  q_event_d = 2'b01;
                  q_valid_d = 1'b1;
               end
               if (auto_req) begin
                  state_d = S_DEAD;
               end else if (pause_req) begin
                  ret_d   = S_AUTO;
                  state_d = S_PAUSE;
               end
            end
         end

         S_PAUSE: begin
            if (pause_req) begin
               state_d = ret_q;
            end
         end

         S_DEAD: begin
            if (jump_req) begin
               state_d        = S_IDLE;
               auto_restart_d = 1'b0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      game_run_d = (state_d == S_PLAY) || (state_d == S_AUTO);
   end

   // Mode registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         ret_q          <= S_IDLE;
         auto_restart_q <= 1'b0;
         cnt_q          <= '0;
         lives_q        <= C_LIVES;
         invuln_q       <= 1'b0;
         episode_q      <= '0;
         q_event_q      <= 2'b00;
         q_valid_q      <= 1'b0;
         game_run_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         ret_q          <= ret_d;
         auto_restart_q <= auto_restart_d;
         cnt_q          <= cnt_d;
         lives_q        <= lives_d;
         invuln_q       <= invuln_d;
         episode_q      <= episode_d;
         q_event_q      <= q_event_d;
         q_valid_q      <= q_valid_d;
         game_run_q     <= game_run_d;
      end
   end

   // Previous obstacle position for edge detection at the trigger point
   always_ff @(posedge clk) begin
      prev_pos_q <= obstacle_pos;
   end

   assign state         = state_q;
   assign game_run      = game_run_q;
   assign q_event       = q_event_q;
   assign q_event_valid = q_valid_q;
   assign lives_left    = lives_q;
   assign invuln        = invuln_q;
   assign episode_cnt   = episode_q;

`ifdef GAME_STATS_EN
   logic [15:0] survive_q, survive_d;
   logic [15:0] best_q, best_d;

   // Survival frame counter and best-run tracker
   always_comb begin
      survive_d = survive_q;
      best_d    = best_q;
      if ((state_q == S_IDLE) && ((state_d == S_PLAY) || (state_d == S_AUTO))) begin
         survive_d = '0;
      end else if (game_run_q && frame_tick && (survive_q != 16'hFFFF)) begin
         survive_d = survive_q + 16'd1;
      end
      if (((state_d == S_DEAD) && (state_q != S_DEAD)) || ((state_q == S_AUTO) && collide)) begin
         if (survive_q > best_q) begin
            best_d = survive_q;
         end
      end
   end

   // Statistics registers
   always_ff @(posedge clk) begin
      if (rst) begin
         survive_q <= '0;
         best_q    <= '0;
      end else begin
         survive_q <= survive_d;
         best_q    <= best_d;
      end
   end

   assign survive_frames = survive_q;
   assign best_frames    = best_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_game_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_mode_ctrl
//  Purpose  : Self-checking bench for game_mode_ctrl: directed scenarios
//             followed by randomized stimulus against a behavioural model.
//  Options  : GAME_STATS_EN also checks survive_frames / best_frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_mode_ctrl;

   localparam int TRIG = 624;
   localparam int NLIV = 3;
   localparam int INVF = 60;
   localparam int RSTF = 30;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_tick = 1'b0;
   logic        jump_req = 1'b0;
   logic        auto_req = 1'b0;
   logic        pause_req = 1'b0;
   logic        collide = 1'b0;
   logic        jumping = 1'b0;
   logic [9:0]  obstacle_pos = '0;
   logic [2:0]  state;
   logic        game_run;
   logic [1:0]  q_event;
   logic        q_event_valid;
   logic [1:0]  lives_left;
   logic        invuln;
   logic [15:0] episode_cnt;
`ifdef GAME_STATS_EN
   logic [15:0] survive_frames;
   logic [15:0] best_frames;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: mode as an integer, counters as plain integers
   int m_mode, m_ret, m_lives, m_inv_left, m_restart_left, m_ep, m_qe, m_run;
   bit m_inv, m_restart, m_qv;
   int m_prev_pos;
   int m_surv, m_best;

   game_mode_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .frame_tick    (frame_tick),
      .jump_req      (jump_req),
      .auto_req      (auto_req),
      .pause_req     (pause_req),
      .collide       (collide),
      .jumping       (jumping),
      .obstacle_pos  (obstacle_pos),
      .state         (state),
      .game_run      (game_run),
      .q_event       (q_event),
      .q_event_valid (q_event_valid),
      .lives_left    (lives_left),
      .invuln        (invuln),
      .episode_cnt   (episode_cnt)
`ifdef GAME_STATS_EN
      ,
      .survive_frames(survive_frames),
      .best_frames   (best_frames)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one clock using the inputs presented this cycle
   task automatic model_clock();
      int old_mode = m_mode;
      int old_surv = m_surv;
      bit entered_dead;
      m_qv = 1'b0;
      if (rst) begin
         m_mode = 0; m_ret = 0; m_lives = NLIV; m_inv = 0; m_inv_left = 0;
         m_restart = 0; m_restart_left = 0; m_ep = 0; m_qe = 0;
         m_surv = 0; m_best = 0;
      end else begin
         case (m_mode)
            0: if (m_restart) begin
                  if (auto_req) begin
                     m_mode = 3; m_restart = 0;
                  end else if (frame_tick) begin
                     m_restart_left--;
                     if (m_restart_left == 0) begin m_mode = 2; m_restart = 0; end
                  end
               end else if (jump_req) begin
                  m_mode = 1; m_lives = NLIV;
               end else if (auto_req) begin
                  m_mode = 2;
               end
            1: if (collide && !m_inv) begin
                  if (m_lives > 1) begin
                     m_lives--; m_inv = 1; m_inv_left = INVF;
                  end else begin
                     m_lives = 0; m_mode = 3;
                  end
               end else begin
                  if (m_inv && frame_tick) begin
                     m_inv_left--;
                     if (m_inv_left == 0) m_inv = 0;
                  end
                  if (pause_req) begin m_ret = 1; m_mode = 4; end
               end
            2: if (collide) begin
                  m_mode = 0; m_restart = 1; m_restart_left = RSTF;
                  m_ep = (m_ep + 1) % 65536;
                  m_qe = jumping ? 3 : 2; m_qv = 1;
               end else begin
                  if (int'(obstacle_pos) == TRIG && m_prev_pos != TRIG) begin
                     m_qe = 1; m_qv = 1;
                  end
                  if (auto_req) m_mode = 3;
                  else if (pause_req) begin m_ret = 2; m_mode = 4; end
               end
            4: if (pause_req) m_mode = m_ret;
            3: if (jump_req) begin m_mode = 0; m_restart = 0; end
            default: m_mode = 0;
         endcase
         // statistics
         entered_dead = (m_mode == 3) && (old_mode != 3);
         if (old_mode == 0 && (m_mode == 1 || m_mode == 2)) m_surv = 0;
         else if (m_run == 1 && frame_tick && m_surv < 65535) m_surv++;
         if (entered_dead || (old_mode == 2 && collide))
            if (old_surv > m_best) m_best = old_surv;
      end
      m_run = (m_mode == 1 || m_mode == 2) ? 1 : 0;
      m_prev_pos = int'(obstacle_pos);
   endtask

   // One clock: model update, compare every output, then drop the pulses
   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
      chk("state", 32'(state), 32'(m_mode));
      chk("game_run", 32'(game_run), 32'(m_run));
      chk("q_event", 32'(q_event), 32'(m_qe));
      chk("q_event_valid", 32'(q_event_valid), 32'(m_qv));
      chk("lives_left", 32'(lives_left), 32'(m_lives));
      chk("invuln", 32'(invuln), 32'(m_inv));
      chk("episode_cnt", 32'(episode_cnt), 32'(m_ep));
`ifdef GAME_STATS_EN
      chk("survive_frames", 32'(survive_frames), 32'(m_surv));
      chk("best_frames", 32'(best_frames), 32'(m_best));
`endif
      rst = 0; jump_req = 0; auto_req = 0; pause_req = 0; collide = 0; frame_tick = 0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1; step();
      end
   endtask

   int pulses;

   initial begin
      m_mode = 0; m_run = 0; m_prev_pos = 0; m_surv = 0; m_best = 0;
      // reset
      rst = 1; step(); rst = 1; step();
      chk("rst_state", 32'(state), 0);
      chk("rst_lives", 32'(lives_left), NLIV);
      chk("rst_episode", 32'(episode_cnt), 0);

      // manual play, lives and invulnerability
      jump_req = 1; step();
      chk("play_state", 32'(state), 1);
      chk("play_run", 32'(game_run), 1);
      collide = 1; step();
      chk("hit1_lives", 32'(lives_left), 2);
      chk("hit1_inv", 32'(invuln), 1);
      collide = 1; step();
      chk("inv_ignore", 32'(lives_left), 2);
      ticks(INVF - 1);
      chk("inv_hold", 32'(invuln), 1);
      ticks(1);
      chk("inv_clear", 32'(invuln), 0);
      collide = 1; step(); ticks(INVF);
      collide = 1; step();
      chk("dead_state", 32'(state), 3);
      chk("dead_lives", 32'(lives_left), 0);
      jump_req = 1; step();
      chk("dead_to_idle", 32'(state), 0);

      // auto play and pass event
      auto_req = 1; step();
      chk("auto_state", 32'(state), 2);
      obstacle_pos = 10'd623; step();
      obstacle_pos = 10'd624;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (q_event_valid) pulses++;
      end
      chk("pass_pulses", 32'(pulses), 1);
      chk("pass_code", 32'(q_event), 1);

      // auto deaths and restart delay
      collide = 1; jumping = 1; step(); jumping = 0;
      chk("air_death", 32'(q_event), 3);
      chk("air_state", 32'(state), 0);
      chk("episode1", 32'(episode_cnt), 1);
      ticks(RSTF);
      chk("restart_auto", 32'(state), 2);
      collide = 1; step();
      chk("ground_death", 32'(q_event), 2);
      ticks(RSTF);

      // pause in auto
      pause_req = 1; step();
      chk("pause_state", 32'(state), 4);
      chk("pause_run", 32'(game_run), 0);
      collide = 1; step();
      pause_req = 1; step();
      chk("resume_auto", 32'(state), 2);
      auto_req = 1; step();
      chk("auto_abort", 32'(state), 3);
      jump_req = 1; step();

      // last life collision beats pause
      jump_req = 1; step();
      collide = 1; step(); ticks(INVF);
      collide = 1; step(); ticks(INVF);
      collide = 1; pause_req = 1; step();
      chk("hit_beats_pause", 32'(state), 3);
      jump_req = 1; step();

      // reset during restart delay
      auto_req = 1; step();
      collide = 1; step(); ticks(5);
      rst = 1; step();
      chk("rst_ep", 32'(episode_cnt), 0);
      ticks(RSTF + 10);
      chk("no_restart", 32'(state), 0);

      // randomized phase
      for (int i = 0; i < 8000; i++) begin
         rst        = ($urandom_range(0, 999) == 0);
         frame_tick = ($urandom_range(0, 1) == 1);
         jump_req   = ($urandom_range(0, 15) == 0);
         auto_req   = ($urandom_range(0, 19) == 0);
         pause_req  = ($urandom_range(0, 15) == 0);
         collide    = ($urandom_range(0, 24) == 0);
         jumping    = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 3))
            0:       obstacle_pos = 10'd624;
            1:       obstacle_pos = 10'd623;
            default: obstacle_pos = 10'($urandom_range(0, 1023));
         endcase
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
